// File: rtl/ws2812b_frame_ctrl.sv
// WS2812B frame scheduler: double-buffered pixel store, refresh tick divider, and a
// FETCH/SEND/DRAIN/LATCH sequencer feeding a 24-bit pixel encoder over valid/ready.
module ws2812b_frame_ctrl #(
   parameter int LED_COUNT    = 8,
   parameter int AW           = 3,
   parameter int CLK_HZ       = 12000000,
   parameter int REFRESH_HZ   = 120,
   parameter int LATCH_CYCLES = 1200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data,
   input  logic          commit,
   output logic          pix_valid,
   output logic [23:0]   pix_data,
   input  logic          pix_ready,
   input  logic          enc_idle,
   output logic          latch,
   output logic          frame_done,
   output logic          commit_pending,
   output logic          overrun
);

   localparam int PERIOD = CLK_HZ / REFRESH_HZ;
   localparam int DW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int LW     = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam int DEPTH  = 2 ** AW;

   localparam logic [DW-1:0] DIV_LAST = DW'(PERIOD - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
   localparam logic [AW-1:0] IDX_LAST = AW'(LED_COUNT - 1);
   localparam logic [AW:0]   LED_N    = (AW + 1)'(LED_COUNT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_DRAIN,
      S_LATCH
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          bank_sel_q, bank_sel_d;
   logic          has_frame_q, has_frame_d;
   logic          commit_pending_q, commit_pending_d;
   logic          overrun_q, overrun_d;
   logic          start_pend_q, start_pend_d;
   logic          frame_done_q, frame_done_d;
   logic [23:0]   pix_data_q, pix_data_d;

   // Bank bank_sel_q is displayed; the other bank is the host's write target.
   logic [23:0]   pix_mem [0:1][0:DEPTH-1];

   logic          tick;
   logic          go;
   logic          swap;
   logic          mem_we;

   assign tick   = (div_q == DIV_LAST);
   assign go     = (tick || start_pend_q) && (has_frame_q || commit_pending_q);
   assign swap   = (state_q == S_IDLE) && go && commit_pending_q;
   assign mem_we = wr_en && ({1'b0, wr_addr} < LED_N);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         pix_mem[~bank_sel_q][wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (pix_ready) begin
               state_d = (idx_q == IDX_LAST) ? S_DRAIN : S_FETCH;
            end
         end
         S_DRAIN: begin
            if (enc_idle) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      div_d            = tick ? '0 : div_q + 1'b1;
      idx_d            = idx_q;
      lat_d            = lat_q;
      bank_sel_d       = bank_sel_q;
      has_frame_d      = has_frame_q;
      overrun_d        = overrun_q;
      start_pend_d     = start_pend_q;
      pix_data_d       = pix_data_q;
      frame_done_d     = 1'b0;
      commit_pending_d = swap ? 1'b0 : (commit_pending_q || commit);

      if (swap) begin
         bank_sel_d  = ~bank_sel_q;
         has_frame_d = 1'b1;
      end

      // A tick mid-frame is remembered as a single queued start.
      if (tick && (state_q != S_IDLE)) begin
         overrun_d    = 1'b1;
         start_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (go) begin
               idx_d        = '0;
               start_pend_d = 1'b0;
            end
         end
         S_FETCH: begin
            pix_data_d = pix_mem[bank_sel_q][idx_q];
         end
         S_SEND: begin
            if (pix_ready && (idx_q != IDX_LAST)) begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            lat_d = '0;
         end
         S_LATCH: begin
            lat_d        = lat_q + 1'b1;
            frame_done_d = (lat_q == LAT_LAST);
         end
         default: begin
            idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q            <= '0;
         idx_q            <= '0;
         lat_q            <= '0;
         bank_sel_q       <= 1'b0;
         has_frame_q      <= 1'b0;
         commit_pending_q <= 1'b0;
         overrun_q        <= 1'b0;
         start_pend_q     <= 1'b0;
         frame_done_q     <= 1'b0;
         pix_data_q       <= '0;
      end else begin
         div_q            <= div_d;
         idx_q            <= idx_d;
         lat_q            <= lat_d;
         bank_sel_q       <= bank_sel_d;
         has_frame_q      <= has_frame_d;
         commit_pending_q <= commit_pending_d;
         overrun_q        <= overrun_d;
         start_pend_q     <= start_pend_d;
         frame_done_q     <= frame_done_d;
         pix_data_q       <= pix_data_d;
      end
   end

   always_comb begin
      pix_valid      = (state_q == S_SEND);
      latch          = (state_q == S_LATCH);
      pix_data       = pix_data_q;
      frame_done     = frame_done_q;
      commit_pending = commit_pending_q;
      overrun        = overrun_q;
   end

endmodule

// File: doc/ws2812b_frame_ctrl.md
Name: ws2812b_frame_ctrl

Overview:
- Frame scheduler for a WS2812B strip of LED_COUNT pixels.
- Holds a double-buffered pixel store (front bank is displayed, back bank is written by the host/I2C register side).
- On each refresh tick it streams front-bank pixels, in address order, to the 24-bit-per-pixel bit encoder over a valid/ready handshake, then holds a latch gap.
- Host commits swap banks only at frame boundaries, so no frame is ever torn.

Parameters:
- LED_COUNT, 8, number of pixels per frame (>=1)
- AW, 3, pixel address width, 2**AW >= LED_COUNT
- CLK_HZ, 12000000, clk frequency
- REFRESH_HZ, 120, frame tick rate; PERIOD = CLK_HZ/REFRESH_HZ cycles
- LATCH_CYCLES, 1200, line-low reset gap after last pixel (100 us at 12 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe into back bank
- wr_addr  in  AW  pixel index
- wr_data  in  24  GRB pixel, bit 23 = G7, sent first
- commit  in  1  request front/back swap at next frame start
- pix_valid  out  1  pixel offered to encoder
- pix_data  out  24  pixel value, stable while pix_valid=1
- pix_ready  in  1  encoder accepts pixel
- enc_idle  in  1  encoder has finished shifting its last bit
- latch  out  1  high during latch gap; encoder holds line low
- frame_done  out  1  one-cycle pulse at end of latch gap
- commit_pending  out  1  commit accepted, swap not yet done
- overrun  out  1  sticky: tick arrived while frame still in progress

Behaviour:
- Reset values: all outputs 0, pix_data 0, state IDLE, tick divider 0, bank_sel 0, has_frame 0. RAM contents are not cleared.
- Tick divider:
  - Counts 0..PERIOD-1, free-running from reset.
  - tick is asserted when count == PERIOD-1.
- Writes:
  - wr_en with wr_addr < LED_COUNT writes the back bank at that edge.
  - wr_addr >= LED_COUNT is ignored.
  - Writes never touch the front bank, in any state.
- Commit:
  - commit sets commit_pending; repeated commits while pending have no extra effect.
  - Same-cycle wr_en + commit: the write lands before the swap.
  - Writes after commit but before the swap also land in the bank about to be shown.
- Swap:
  - Happens in the cycle IDLE leaves on tick, if commit_pending: bank_sel toggles, commit_pending clears, has_frame sets.
  - After a swap the back bank holds the previously displayed frame; the host rewrites every pixel it needs.
- FSM:
  - IDLE: on tick with (has_frame or commit_pending), perform the swap rule, set idx=0, go to FETCH. Otherwise stay.
  - FETCH (1 cycle): read front[idx] into pix_data, go to SEND.
  - SEND: pix_valid=1. On pix_valid&pix_ready: pix_valid drops next cycle; if idx==LED_COUNT-1 go to DRAIN, else idx+1 and go to FETCH.
  - DRAIN: wait for enc_idle=1, then go to LATCH with latch counter 0.
  - LATCH: latch=1 for exactly LATCH_CYCLES cycles, then go to IDLE with frame_done=1 for one cycle.
- Latency:
  - Tick edge to pix_valid=1 is 2 cycles.
  - Accept edge to next pix_valid=1 is 2 cycles (one cycle low).
  - pix_data must not change while pix_valid=1 and pix_ready=0.
- Overrun:
  - A tick in any state other than IDLE sets overrun (sticky until rst) and is remembered as one pending start.
  - The next frame starts from IDLE on the cycle after frame_done; at most one pending start is queued.
- Reset mid-frame: at the rst edge, all state returns to reset values, pix_valid drops, pending commit and queued start are discarded.
- With no commit ever issued, no frame is sent (pix_valid stays 0); ticks in IDLE are ignored.

Test Plan:
Bench parameters: LED_COUNT=4, PERIOD=200, LATCH_CYCLES=20, encoder model takes 10 cycles per pixel.

1. Reset, write addr0..3 = 0x010000, 0x000100, 0x000001, 0xFFFFFF, then commit.
   -> commit_pending=1 until the first tick (cycle 199); pix_valid at 201; those 4 values appear in order; latch high 20 cycles; frame_done pulse; commit_pending=0.
2. Hold pix_ready=0 for 50 cycles in SEND.
   -> pix_valid stays 1 and pix_data is unchanged; after ready, the next pixel is valid 2 cycles later.
3. After frame 1, write addr1=0x123456 without commit.
   -> the next two frames still show 0x000100 at idx1.
   Then commit.
   -> the following frame shows the back-bank content with 0x123456 at idx1.
4. Write with wr_addr=5, and commit in the same cycle as write addr2=0xABCDEF.
   -> no effect from addr5; the displayed frame has 0xABCDEF at idx2.
5. Set encoder at 60 cycles/pixel.
   -> tick during DRAIN sets overrun=1; the next frame starts the cycle after frame_done; overrun stays 1.
6. Assert rst during SEND of pixel 2.
   -> next edge: pix_valid=0, latch=0, commit_pending=0, has_frame=0; no frames follow until a new commit.
